// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button front-end and run-control FSM for the seconds counter.
// Each raw button passes through a 2-FF synchroniser, a debouncer and a
// rising-edge detector. The resulting press pulses drive a CLEAR/IDLE/RUN/PAUSE
// FSM. All outputs are decoded from the registered state only.
//
// Optional feature macro: SW_AUTOSTOP_EN
//   defined   : RUN pauses itself when time_reading hits 8'h99, and a start
//               press cannot resume while the reading is still 99.
//   undefined : time_reading is ignored and the counter wraps freely.
//
// state | meaning
// ------+-----------------------------------------------------------
// CLEAR | one-cycle clear request to the counter (init_regs high)
// IDLE  | cleared and waiting for the first start press
// RUN   | counter enabled
// PAUSE | counter frozen; start resumes, reset clears

module stopwatch_ctrl #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_stop,
  input  logic       btn_reset,
  input  logic [7:0] time_reading,
  output logic       init_regs,
  output logic       count_enabled,
  output logic [1:0] status
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  localparam logic [1:0] S_CLEAR = 2'b00;
  localparam logic [1:0] S_IDLE  = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_PAUSE = 2'b11;

  // bit 0: start/stop, bit 1: reset
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_reset, btn_start_stop};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic          db_dly_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Debounce: accept the synchronised level only after it has disagreed
    // with the accepted level for DEB_CYCLES consecutive cycles.
    always_comb begin
      db_d  = db_q;
      cnt_d = cnt_q;
      if (sync2_q == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Synchroniser, debounce state and edge-detect delay flop.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        db_q     <= 1'b0;
        db_dly_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q  <= btn_raw[i];
        sync2_q  <= sync1_q;
        db_q     <= db_d;
        db_dly_q <= db_q;
        cnt_q    <= cnt_d;
      end
    end

    // One-cycle pulse on an accepted rising edge; release produces nothing.
    assign press[i] = db_q & ~db_dly_q;
  end

  logic start_press;
  logic reset_press;
  logic at_limit;

  assign start_press = press[0];
  assign reset_press = press[1];

`ifdef SW_AUTOSTOP_EN
  assign at_limit = (time_reading == 8'h99);
`else
  // Reading is not needed when the counter is allowed to wrap.
  logic unused_time_reading;
  assign unused_time_reading = ^time_reading;
  assign at_limit = 1'b0;
`endif

  logic [1:0] state_q;
  logic [1:0] state_d;

  // Next-state logic; reset press outranks autostop, which outranks start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: state_d = S_IDLE;
      S_IDLE: begin
        if (reset_press)      state_d = S_CLEAR;
        else if (start_press) state_d = S_RUN;
      end
      S_RUN: begin
        if (reset_press)      state_d = S_CLEAR;
        else if (at_limit)    state_d = S_PAUSE;
        else if (start_press) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (reset_press)                   state_d = S_CLEAR;
        else if (start_press && !at_limit) state_d = S_RUN;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // State register; reset lands in CLEAR so the counter is cleared on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_CLEAR;
    else        state_q <= state_d;
  end

  assign init_regs     = (state_q == S_CLEAR);
  assign count_enabled = (state_q == S_RUN);
  assign status        = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DEB_CYCLES=4.
// Expected output words {init_regs, count_enabled, status} are queued per
// clock as stimulus is applied and compared one per cycle afterwards.

module tb_stopwatch_ctrl;

  localparam logic [1:0] S_CLEAR = 2'b00;
  localparam logic [1:0] S_IDLE  = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_PAUSE = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       btn_start_stop;
  logic       btn_reset;
  logic [7:0] time_reading;
  logic       init_regs;
  logic       count_enabled;
  logic [1:0] status;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  stopwatch_ctrl #(.DEB_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_start_stop (btn_start_stop),
    .btn_reset      (btn_reset),
    .time_reading   (time_reading),
    .init_regs      (init_regs),
    .count_enabled  (count_enabled),
    .status         (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] exp_of(logic [1:0] st);
    return {st == S_CLEAR, st == S_RUN, st};
  endfunction

  task automatic push_n(int n, logic [1:0] st, string tag);
    exp_t x;
    for (int k = 0; k < n; k++) begin
      x.v   = exp_of(st);
      x.tag = tag;
      sb.push_back(x);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_start_stop = 1'b0; btn_reset = 1'b0; time_reading = 8'h00;
    #2;
    total++;
    if ({init_regs, count_enabled, status} !== exp_of(S_CLEAR)) begin
      bad++;
      $display("FAIL reset_async: got %b want %b", {init_regs, count_enabled, status}, exp_of(S_CLEAR));
    end
    @(posedge clk); #1;
    total++;
    if ({init_regs, count_enabled, status} !== exp_of(S_CLEAR)) begin
      bad++;
      $display("FAIL reset_held: got %b want %b", {init_regs, count_enabled, status}, exp_of(S_CLEAR));
    end
    rst_n = 1'b1;
    push_n(3, S_IDLE, "reset_release");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      total++;
      if ({init_regs, count_enabled, status} !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.tag, {init_regs, count_enabled, status}, e.v);
      end
    end
  endtask

  task automatic test_start();
    btn_start_stop = 1'b1;
    push_n(6, S_IDLE, "start_latency");
    push_n(1, S_RUN, "start_edge7");
    push_n(100, S_RUN, "start_held");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      total++;
      if ({init_regs, count_enabled, status} !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.tag, {init_regs, count_enabled, status}, e.v);
      end
    end
    btn_start_stop = 1'b0;
    push_n(8, S_RUN, "start_release");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      total++;
      if ({init_regs, count_enabled, status} !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.tag, {init_regs, count_enabled, status}, e.v);
      end
    end
  endtask

  task automatic test_clear();
    btn_reset = 1'b1;
    push_n(6, S_RUN, "clear_latency");
    push_n(1, S_CLEAR, "clear_pulse");
    push_n(5, S_IDLE, "clear_after");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      total++;
      if ({init_regs, count_enabled, status} !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.tag, {init_regs, count_enabled, status}, e.v);
      end
    end
    btn_reset = 1'b0;
    push_n(8, S_IDLE, "clear_release");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      total++;
      if ({init_regs, count_enabled, status} !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.tag, {init_regs, count_enabled, status}, e.v);
      end
    end
  endtask

  task automatic test_glitch();
    // 3-cycle glitch, then clean run press, then clean pause press
    logic       lvl [6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] pre [6]  = '{S_IDLE, S_IDLE, S_IDLE, S_RUN, S_RUN, S_PAUSE};
    logic [1:0] post [6] = '{S_IDLE, S_IDLE, S_RUN, S_RUN, S_PAUSE, S_PAUSE};
    int         npre [6] = '{3, 10, 6, 8, 6, 8};
    int         npost [6] = '{0, 0, 4, 0, 4, 0};
    for (int s = 0; s < 6; s++) begin
      btn_start_stop = lvl[s];
      push_n(npre[s], pre[s], "glitch_pre");
      push_n(npost[s], post[s], "glitch_post");
      while (sb.size() > 0) begin
        e = sb.pop_front();
        @(posedge clk); #1;
        total++;
        if ({init_regs, count_enabled, status} !== e.v) begin
          bad++;
          $display("FAIL %s step%0d: got %b want %b", e.tag, s, {init_regs, count_enabled, status}, e.v);
        end
      end
    end
  endtask

  task automatic test_both();
    // From PAUSE, then from IDLE: simultaneous presses always clear
    logic [1:0] from [2] = '{S_PAUSE, S_IDLE};
    for (int s = 0; s < 2; s++) begin
      btn_start_stop = 1'b1;
      btn_reset      = 1'b1;
      push_n(6, from[s], "both_latency");
      push_n(1, S_CLEAR, "both_clear");
      push_n(5, S_IDLE, "both_after");
      while (sb.size() > 0) begin
        e = sb.pop_front();
        @(posedge clk); #1;
        total++;
        if ({init_regs, count_enabled, status} !== e.v) begin
          bad++;
          $display("FAIL %s pass%0d: got %b want %b", e.tag, s, {init_regs, count_enabled, status}, e.v);
        end
      end
      btn_start_stop = 1'b0;
      btn_reset      = 1'b0;
      push_n(8, S_IDLE, "both_release");
      while (sb.size() > 0) begin
        e = sb.pop_front();
        @(posedge clk); #1;
        total++;
        if ({init_regs, count_enabled, status} !== e.v) begin
          bad++;
          $display("FAIL %s pass%0d: got %b want %b", e.tag, s, {init_regs, count_enabled, status}, e.v);
        end
      end
    end
  endtask

  task automatic test_async();
    btn_start_stop = 1'b1;
    push_n(6, S_IDLE, "async_start");
    push_n(4, S_RUN, "async_run");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      total++;
      if ({init_regs, count_enabled, status} !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.tag, {init_regs, count_enabled, status}, e.v);
      end
    end
    btn_start_stop = 1'b0;
    push_n(8, S_RUN, "async_release");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      total++;
      if ({init_regs, count_enabled, status} !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.tag, {init_regs, count_enabled, status}, e.v);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({init_regs, count_enabled, status} !== exp_of(S_CLEAR)) begin
      bad++;
      $display("FAIL async_drop: got %b want %b", {init_regs, count_enabled, status}, exp_of(S_CLEAR));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_n(3, S_IDLE, "async_recover");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      total++;
      if ({init_regs, count_enabled, status} !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.tag, {init_regs, count_enabled, status}, e.v);
      end
    end
  endtask

  task automatic test_autostop();
    logic [1:0] at99;
    logic [1:0] after_start;
`ifdef SW_AUTOSTOP_EN
    at99        = S_PAUSE;
    after_start = S_PAUSE;
`else
    at99        = S_RUN;
    after_start = S_PAUSE;
`endif
    btn_start_stop = 1'b1;
    push_n(6, S_IDLE, "auto_start");
    push_n(4, S_RUN, "auto_run");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      total++;
      if ({init_regs, count_enabled, status} !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.tag, {init_regs, count_enabled, status}, e.v);
      end
    end
    btn_start_stop = 1'b0;
    push_n(8, S_RUN, "auto_release");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      total++;
      if ({init_regs, count_enabled, status} !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.tag, {init_regs, count_enabled, status}, e.v);
      end
    end
    time_reading = 8'h99;
    push_n(3, at99, "auto_limit");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      total++;
      if ({init_regs, count_enabled, status} !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.tag, {init_regs, count_enabled, status}, e.v);
      end
    end
    btn_start_stop = 1'b1;
    push_n(6, at99, "auto_start_wait");
    push_n(4, after_start, "auto_start_press");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      total++;
      if ({init_regs, count_enabled, status} !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.tag, {init_regs, count_enabled, status}, e.v);
      end
    end
    btn_start_stop = 1'b0;
    btn_reset      = 1'b1;
    push_n(6, after_start, "auto_reset_wait");
    push_n(1, S_CLEAR, "auto_reset_clear");
    push_n(5, S_IDLE, "auto_reset_idle");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      total++;
      if ({init_regs, count_enabled, status} !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.tag, {init_regs, count_enabled, status}, e.v);
      end
    end
    btn_reset    = 1'b0;
    time_reading = 8'h00;
    push_n(8, S_IDLE, "auto_final");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      total++;
      if ({init_regs, count_enabled, status} !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.tag, {init_regs, count_enabled, status}, e.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_clear();
    test_glitch();
    test_both();
    test_async();
    test_autostop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
